// File: rtl/zic_prio_mmr.sv
// ZIC interrupt controller: MMR register file, per-line edge/level pending capture,
// registered priority/threshold arbitration and a claim (read) / complete (write) handshake.
module zic_prio_mmr #(
  parameter  int NUM_IRQ = 48,
  parameter  int PRIO_W  = 3,
  parameter  int ADDR_W  = 16,
  localparam int IDW     = $clog2(NUM_IRQ + 1)
) (
  input  logic               zic_clk,
  input  logic               zic_rst,
  input  logic               zic_mmr_write_en_i,
  input  logic [ADDR_W-1:0]  zic_mmr_write_addr_i,
  input  logic [31:0]        zic_mmr_write_data_i,
  input  logic               zic_mmr_read_en_i,
  input  logic [ADDR_W-1:0]  zic_mmr_read_addr_i,
  output logic [31:0]        zic_mmr_read_data_o,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  output logic               zic_irq_o,
  output logic [IDW-1:0]     zic_irq_id_o
);

  localparam logic [ADDR_W-1:0] ADDR_INFO   = ADDR_W'(32'h0000);
  localparam logic [ADDR_W-1:0] ADDR_THRESH = ADDR_W'(32'h0004);
  localparam logic [ADDR_W-1:0] ADDR_CLAIM  = ADDR_W'(32'h0008);
  localparam logic [ADDR_W-1:0] ADDR_NXTP   = ADDR_W'(32'h000C);
  localparam int unsigned       CTRL_BASE   = 32'h0100;
  localparam logic [31:0]       INFO_WORD   = {20'd0, 4'(PRIO_W), 8'(NUM_IRQ)};

  // Per-line state
  logic [NUM_IRQ-1:0] en_q,       en_d;
  logic [NUM_IRQ-1:0] edge_q,     edge_d;
  logic [NUM_IRQ-1:0] pend_q,     pend_d;
  logic [NUM_IRQ-1:0] act_q,      act_d;
  logic [NUM_IRQ-1:0] src_prev_q, src_prev_d;
  logic [PRIO_W-1:0]  prio_q [NUM_IRQ];
  logic [PRIO_W-1:0]  prio_d [NUM_IRQ];

  // Global state
  logic [PRIO_W-1:0]  thresh_q,  thresh_d;
  logic [IDW-1:0]     best_id_q, best_id_d;
  logic [31:0]        rdata_q,   rdata_d;
  logic [PRIO_W-1:0]  arb_prio;

  // Access decode
  logic               wr_thresh;
  logic               wr_claim;
  logic               rd_claim;
  logic               claim_fire;
  logic [NUM_IRQ-1:0] wr_ctrl;
  logic [NUM_IRQ-1:0] claim_hit;
  logic [NUM_IRQ-1:0] cmpl_hit;

  assign wr_thresh  = zic_mmr_write_en_i && (zic_mmr_write_addr_i == ADDR_THRESH);
  assign wr_claim   = zic_mmr_write_en_i && (zic_mmr_write_addr_i == ADDR_CLAIM);
  assign rd_claim   = zic_mmr_read_en_i  && (zic_mmr_read_addr_i  == ADDR_CLAIM);
  assign claim_fire = rd_claim && (best_id_q != '0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_ctrl   = '0;
    claim_hit = '0;
    cmpl_hit  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      wr_ctrl[i]   = zic_mmr_write_en_i &&
                     (zic_mmr_write_addr_i == ADDR_W'(CTRL_BASE + 4 * i));
      claim_hit[i] = claim_fire && (best_id_q == IDW'(i + 1));
      cmpl_hit[i]  = wr_claim && act_q[i] && (zic_mmr_write_data_i == 32'(i + 1));
    end
  end

  // Register, pending and in-service next state
  always_comb begin
    en_d       = en_q;
    edge_d     = edge_q;
    pend_d     = pend_q;
    act_d      = act_q;
    prio_d     = prio_q;
    thresh_d   = thresh_q;
    // Edge history always follows the source, so a mode switch can never see a stale edge.
    src_prev_d = irq_src_i;

    if (wr_thresh) thresh_d = zic_mmr_write_data_i[PRIO_W-1:0];

    for (int i = 0; i < NUM_IRQ; i++) begin
      if (cmpl_hit[i])  act_d[i] = 1'b0;
      if (claim_hit[i]) act_d[i] = 1'b1;

      if (wr_ctrl[i]) begin
        en_d[i]   = zic_mmr_write_data_i[0];
        edge_d[i] = zic_mmr_write_data_i[1];
        prio_d[i] = zic_mmr_write_data_i[8 +: PRIO_W];
      end

      if (wr_ctrl[i] && (zic_mmr_write_data_i[1] != edge_q[i])) begin
        pend_d[i] = 1'b0;
      end else if (edge_q[i]) begin
        // A new edge beats a simultaneous claim or software clear of the same line.
        if (irq_src_i[i] && !src_prev_q[i]) begin
          pend_d[i] = 1'b1;
        end else if (claim_hit[i] || (wr_ctrl[i] && zic_mmr_write_data_i[16])) begin
          pend_d[i] = 1'b0;
        end
      end else begin
        pend_d[i] = irq_src_i[i] & ~act_d[i];
      end
    end
  end

  // Arbitration: seeding the running maximum with THRESH makes the threshold test strict,
  // and only a strictly higher priority displaces the winner, so the lowest index wins ties.
  always_comb begin
    arb_prio  = thresh_q;
    best_id_d = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pend_q[i] && en_q[i] && !act_q[i] && (prio_q[i] > arb_prio)) begin
        arb_prio  = prio_q[i];
        best_id_d = IDW'(i + 1);
      end
    end
  end

  // Read mux: always from current state, so a same-cycle write is not visible yet.
  always_comb begin
    rdata_d = rdata_q;
    if (zic_mmr_read_en_i) begin
      rdata_d = '0;
      if (zic_mmr_read_addr_i == ADDR_INFO) begin
        rdata_d = INFO_WORD;
      end else if (zic_mmr_read_addr_i == ADDR_THRESH) begin
        rdata_d = 32'(thresh_q);
      end else if ((zic_mmr_read_addr_i == ADDR_CLAIM) || (zic_mmr_read_addr_i == ADDR_NXTP)) begin
        rdata_d = 32'(best_id_q);
      end
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (zic_mmr_read_addr_i == ADDR_W'(CTRL_BASE + 4 * i)) begin
          rdata_d[0]            = en_q[i];
          rdata_d[1]            = edge_q[i];
          rdata_d[8 +: PRIO_W]  = prio_q[i];
          rdata_d[16]           = pend_q[i];
          rdata_d[17]           = act_q[i];
        end
      end
    end
  end

  always_ff @(posedge zic_clk or negedge zic_rst) begin
    if (!zic_rst) begin
      en_q       <= '0;
      edge_q     <= '0;
      pend_q     <= '0;
      act_q      <= '0;
      src_prev_q <= '0;
      thresh_q   <= '0;
      best_id_q  <= '0;
      rdata_q    <= '0;
      // NOTE: the priority array is built from flops, not a RAM macro, so it must be reset.
      for (int i = 0; i < NUM_IRQ; i++) prio_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      en_q       <= en_d;
      edge_q     <= edge_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
      src_prev_q <= src_prev_d;
      thresh_q   <= thresh_d;
      best_id_q  <= best_id_d;
      rdata_q    <= rdata_d;
      prio_q     <= prio_d;
    end
  end

  assign zic_mmr_read_data_o = rdata_q;
  assign zic_irq_o           = (best_id_q != '0);
  assign zic_irq_id_o        = best_id_q;

endmodule

// File: tb/tb_zic_prio_mmr.sv
// Directed bench for zic_prio_mmr: default build plus NUM_IRQ=1/PRIO_W=1 and
// NUM_IRQ=255/PRIO_W=7 builds sharing one MMR bus.
module tb_zic_prio_mmr;

  localparam int N_M = 48;
  localparam int N_S = 1;
  localparam int N_L = 255;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            we    = 1'b0;
  logic            re    = 1'b0;
  logic [15:0]     wa    = '0;
  logic [15:0]     ra    = '0;
  logic [31:0]     wd    = '0;
  logic [N_M-1:0]  src_m = '0;
  logic [N_S-1:0]  src_s = '0;
  logic [N_L-1:0]  src_l = '0;
  logic [31:0]     rd_m, rd_s, rd_l;
  logic            irq_m, irq_s, irq_l;
  logic [5:0]      id_m;
  logic [0:0]      id_s;
  logic [7:0]      id_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  zic_prio_mmr #(.NUM_IRQ(N_M), .PRIO_W(3), .ADDR_W(16)) dut_m (
    .zic_clk(clk), .zic_rst(rst_n),
    .zic_mmr_write_en_i(we), .zic_mmr_write_addr_i(wa), .zic_mmr_write_data_i(wd),
    .zic_mmr_read_en_i(re), .zic_mmr_read_addr_i(ra), .zic_mmr_read_data_o(rd_m),
    .irq_src_i(src_m), .zic_irq_o(irq_m), .zic_irq_id_o(id_m)
  );

  zic_prio_mmr #(.NUM_IRQ(N_S), .PRIO_W(1), .ADDR_W(16)) dut_s (
    .zic_clk(clk), .zic_rst(rst_n),
    .zic_mmr_write_en_i(we), .zic_mmr_write_addr_i(wa), .zic_mmr_write_data_i(wd),
    .zic_mmr_read_en_i(re), .zic_mmr_read_addr_i(ra), .zic_mmr_read_data_o(rd_s),
    .irq_src_i(src_s), .zic_irq_o(irq_s), .zic_irq_id_o(id_s)
  );

  zic_prio_mmr #(.NUM_IRQ(N_L), .PRIO_W(7), .ADDR_W(16)) dut_l (
    .zic_clk(clk), .zic_rst(rst_n),
    .zic_mmr_write_en_i(we), .zic_mmr_write_addr_i(wa), .zic_mmr_write_data_i(wd),
    .zic_mmr_read_en_i(re), .zic_mmr_read_addr_i(ra), .zic_mmr_read_data_o(rd_l),
    .irq_src_i(src_l), .zic_irq_o(irq_l), .zic_irq_id_o(id_l)
  );

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; wa = a; wd = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Returns at the negedge after the read edge; rd_* then hold the read data.
  task automatic rd(input logic [15:0] a);
    @(negedge clk);
    re = 1'b1; ra = a;
    @(negedge clk);
    re = 1'b0;
  endtask

  // One-cycle source pulse; returns one edge after the source was sampled high.
  task automatic pulse_m(input logic [N_M-1:0] m);
    @(negedge clk);
    src_m = m;
    @(negedge clk);
    src_m = '0;
  endtask

  function automatic logic [15:0] ctrl(input int i);
    return 16'(32'h100 + 4 * i);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the summary line");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 16'h0000, 32'h0,         32'h0000_0330, "info_default"};
    vecs[1]  = '{1'b0, 16'h0004, 32'h0,         32'h0,         "thresh_reset"};
    vecs[2]  = '{1'b1, 16'h0004, 32'hFFFF_FFFC, 32'h0,         ""};
    vecs[3]  = '{1'b0, 16'h0004, 32'h0,         32'h4,         "thresh_masked"};
    vecs[4]  = '{1'b1, 16'h0114, 32'hFFFF_FFFF, 32'h0,         ""};
    vecs[5]  = '{1'b0, 16'h0114, 32'h0,         32'h0000_0703, "ctrl5_fields"};
    vecs[6]  = '{1'b0, 16'h01C0, 32'h0,         32'h0,         "ctrl48_unmapped"};
    vecs[7]  = '{1'b0, 16'h0116, 32'h0,         32'h0,         "ctrl_misaligned"};
    vecs[8]  = '{1'b0, 16'h0010, 32'h0,         32'h0,         "unmapped_0x10"};
    vecs[9]  = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 32'h0,         ""};
    vecs[10] = '{1'b0, 16'h0000, 32'h0,         32'h0000_0330, "info_read_only"};
    vecs[11] = '{1'b1, 16'h0114, 32'h0,         32'h0,         ""};
    vecs[12] = '{1'b0, 16'h0114, 32'h0,         32'h0,         "ctrl5_cleared"};
    vecs[13] = '{1'b1, 16'h0004, 32'h0,         32'h0,         ""};
    vecs[14] = '{1'b0, 16'h000C, 32'h0,         32'h0,         "nxtp_idle"};

    // Reset values
    cyc(2);
    check("reset_irq", 32'(irq_m), 32'h0);
    check("reset_id", 32'(id_m), 32'h0);
    check("reset_rdata", rd_m, 32'h0);
    rst_n = 1'b1;
    cyc(1);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
      else begin
        rd(vecs[i].addr);
        check(vecs[i].name, rd_m, vecs[i].exp);
      end
    end

    // Same-cycle read and write of THRESH returns the old value
    @(negedge clk);
    we = 1'b1; wa = 16'h0004; wd = 32'h5; re = 1'b1; ra = 16'h0004;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    check("rw_same_cycle_old", rd_m, 32'h0);
    rd(16'h0004);
    check("rw_same_cycle_new", rd_m, 32'h5);
    wr(16'h0004, 32'h0);

    // Edge priority: IRQ3 prio 2, IRQ7 prio 5
    wr(ctrl(3), 32'h0000_0203);
    wr(ctrl(7), 32'h0000_0503);
    pulse_m((N_M'(1) << 3) | (N_M'(1) << 7));
    check("edge_not_yet", 32'(irq_m), 32'h0);
    cyc(1);
    check("edge_best8", 32'(id_m), 32'd8);
    rd(16'h000C);
    check("nxtp_8", rd_m, 32'd8);
    rd(16'h0008);
    check("claim_8", rd_m, 32'd8);
    check("claim_id_stale", 32'(id_m), 32'd8);
    cyc(1);
    check("best4_after_claim", 32'(id_m), 32'd4);
    rd(ctrl(7));
    check("ctrl7_act", rd_m, 32'h0002_0503);
    rd(16'h0008);
    check("claim_4", rd_m, 32'd4);
    wr(16'h0008, 32'd8);
    wr(16'h0008, 32'd4);
    cyc(1);
    check("edge_all_done", 32'(irq_m), 32'h0);
    rd(ctrl(7));
    check("ctrl7_completed", rd_m, 32'h0000_0503);
    wr(ctrl(3), 32'h0);
    wr(ctrl(7), 32'h0);

    // Tie and threshold: IRQ1 and IRQ2 at prio 4
    wr(ctrl(1), 32'h0000_0403);
    wr(ctrl(2), 32'h0000_0403);
    pulse_m((N_M'(1) << 1) | (N_M'(1) << 2));
    cyc(1);
    check("tie_lowest_index", 32'(id_m), 32'd2);
    wr(16'h0004, 32'd4);
    cyc(1);
    check("thresh_equal_blocks", 32'(irq_m), 32'h0);
    wr(16'h0004, 32'd3);
    cyc(1);
    check("thresh_below_reoffers", 32'(id_m), 32'd2);
    wr(ctrl(1), 32'h0);
    wr(ctrl(2), 32'h0);
    wr(16'h0004, 32'h0);
    cyc(1);
    check("mode_change_clears_pend", 32'(irq_m), 32'h0);

    // Level mode: IRQ10 prio 1, source held high
    @(negedge clk);
    src_m[10] = 1'b1;
    wr(ctrl(10), 32'h0000_0101);
    cyc(1);
    check("level_offer", 32'(id_m), 32'd11);
    rd(16'h0008);
    check("level_claim", rd_m, 32'd11);
    cyc(2);
    check("level_no_reoffer", 32'(irq_m), 32'h0);
    rd(ctrl(10));
    check("ctrl10_act", rd_m, 32'h0002_0101);
    wr(16'h0008, 32'd11);
    check("level_complete_lat", 32'(id_m), 32'h0);
    cyc(1);
    check("level_reoffer", 32'(id_m), 32'd11);
    src_m[10] = 1'b0;
    cyc(2);
    check("level_withdrawn", 32'(irq_m), 32'h0);
    rd(16'h0008);
    check("level_claim_empty", rd_m, 32'h0);
    wr(ctrl(10), 32'h0);

    // Boundaries
    rd(16'h0008);
    check("claim_nothing", rd_m, 32'h0);
    wr(ctrl(20), 32'h0000_0303);
    pulse_m(N_M'(1) << 20);
    cyc(1);
    check("irq21_offer", 32'(id_m), 32'd21);
    rd(16'h0008);
    check("irq21_claim", rd_m, 32'd21);
    wr(16'h0008, 32'd0);
    wr(16'h0008, 32'd49);
    wr(16'h0008, 32'd5);
    rd(ctrl(20));
    check("bad_completes_ignored", rd_m, 32'h0002_0303);

    // Edge on the same cycle as the claim of that line
    wr(ctrl(30), 32'h0000_0603);
    pulse_m(N_M'(1) << 30);
    cyc(1);
    check("irq31_offer", 32'(id_m), 32'd31);
    @(negedge clk);
    re = 1'b1; ra = 16'h0008; src_m[30] = 1'b1;
    @(negedge clk);
    re = 1'b0; src_m[30] = 1'b0;
    check("edge_claim_rdata", rd_m, 32'd31);
    rd(ctrl(30));
    check("edge_claim_pend_act", rd_m, 32'h0003_0603);
    wr(16'h0008, 32'd31);
    check("reoffer_not_yet", 32'(id_m), 32'h0);
    cyc(1);
    check("reoffer_after_complete", 32'(id_m), 32'd31);

    // Complete (IRQ21) and claim (IRQ31) in the same cycle
    @(negedge clk);
    we = 1'b1; wa = 16'h0008; wd = 32'd21; re = 1'b1; ra = 16'h0008;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    check("combo_claim", rd_m, 32'd31);
    rd(ctrl(20));
    check("combo_complete21", rd_m, 32'h0000_0303);
    rd(ctrl(30));
    check("combo_claimed31", rd_m, 32'h0002_0603);

    // Reset mid-traffic
    pulse_m(N_M'(1) << 20);
    cyc(1);
    check("pre_reset_irq", 32'(id_m), 32'd21);
    rd(16'h0000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_irq", 32'(irq_m), 32'h0);
    check("async_reset_id", 32'(id_m), 32'h0);
    check("async_reset_rdata", rd_m, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(16'h0000);
    check("info_after_reset", rd_m, 32'h0000_0330);
    for (int i = 0; i < N_M; i++) begin
      rd(ctrl(i));
      check($sformatf("ctrl%0d_after_reset", i), rd_m, 32'h0);
    end

    // Parameter sweep: last line of the 1-line and 255-line builds
    wr(16'h0100, 32'h0000_0103);
    wr(16'h04F8, 32'h0000_7F03);
    rd(16'h0000);
    check("info_small", rd_s, 32'h0000_0101);
    check("info_large", rd_l, 32'h0000_07FF);
    rd(16'h0100);
    check("small_ctrl0", rd_s, 32'h0000_0103);
    rd(16'h04F8);
    check("large_ctrl254", rd_l, 32'h0000_7F03);
    check("main_0x4f8_unmapped", rd_m, 32'h0);
    @(negedge clk);
    src_s[0] = 1'b1; src_l[254] = 1'b1;
    @(negedge clk);
    src_s[0] = 1'b0; src_l[254] = 1'b0;
    cyc(1);
    check("small_offer", 32'(id_s), 32'd1);
    check("large_offer", 32'(id_l), 32'd255);
    rd(16'h0008);
    check("small_claim", rd_s, 32'd1);
    check("large_claim", rd_l, 32'd255);
    rd(16'h04F8);
    check("large_act", rd_l, 32'h0002_7F03);
    wr(16'h0008, 32'd1);
    wr(16'h0008, 32'd255);
    cyc(1);
    check("small_idle", 32'(irq_s), 32'h0);
    check("large_idle", 32'(irq_l), 32'h0);
    rd(16'h0100);
    check("small_completed", rd_s, 32'h0000_0103);
    rd(16'h04F8);
    check("large_completed", rd_l, 32'h0000_7F03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
